// File: rtl/obstacle_spawn_scheduler.sv
// Obstacle spawn scheduler: draws a gap and type from the 4-bit LFSR,
// counts frame ticks, and issues spawn pulses while capping obstacles on screen.
module obstacle_spawn_scheduler #(
  parameter int MIN_GAP   = 20,
  parameter int GAP_SCALE = 4,
  parameter int CNT_W     = 8,
  parameter int MAX_OBS   = 2,
  parameter int ACW       = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           game_active,
  input  logic           tick,
  input  logic [3:0]     lfsr_val,
  input  logic           obstacle_done,
  output logic           lfsr_en,
  output logic           spawn,
  output logic [1:0]     obstacle_type,
  output logic [ACW-1:0] active_count,
  output logic           holding
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_LATCH,
    S_WAIT,
    S_HOLD,
    S_SPAWN
  } state_t;

  localparam logic [CNT_W+3:0] GAP_MAX = {4'b0, {CNT_W{1'b1}}};

  state_t           r_state;
  logic [CNT_W-1:0] r_gap;
  logic [1:0]       r_type;
  logic             r_lfsr_en;
  logic             r_spawn;
  logic [1:0]       r_obs_type;
  logic [ACW-1:0]   r_active_count;
  logic             r_holding;

  logic [CNT_W+3:0] w_gap_full;
  logic [CNT_W-1:0] w_gap_sat;
  logic             w_room;
  logic             w_inc;
  logic             w_dec;
  logic [ACW-1:0]   w_cnt_nx;

  assign w_gap_full = (CNT_W+4)'(MIN_GAP)
                    + (CNT_W+4)'(lfsr_val) * (CNT_W+4)'(GAP_SCALE);
  assign w_gap_sat  = (w_gap_full > GAP_MAX) ? {CNT_W{1'b1}}
                                             : w_gap_full[CNT_W-1:0];

  assign w_room = r_active_count < ACW'(MAX_OBS);
  assign w_inc  = (r_state == S_SPAWN);
  // A done pulse with nothing on screen is dropped so the count cannot wrap.
  assign w_dec  = obstacle_done && (r_active_count != '0);

  always_comb begin
    w_cnt_nx = r_active_count;
    if (w_inc && !w_dec)
      w_cnt_nx = r_active_count + 1'b1;
    else if (!w_inc && w_dec)
      w_cnt_nx = r_active_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || !game_active) begin
      r_state        <= S_IDLE;
      r_gap          <= '0;
      r_type         <= '0;
      r_lfsr_en      <= 1'b0;
      r_spawn        <= 1'b0;
      r_obs_type     <= '0;
      r_active_count <= '0;
      r_holding      <= 1'b0;
    end else begin
      r_lfsr_en      <= 1'b0;
      r_spawn        <= 1'b0;
      r_obs_type     <= '0;
      r_holding      <= 1'b0;
      r_active_count <= w_cnt_nx;
      unique case (r_state)
        S_IDLE: begin
          r_state   <= S_DRAW;
          r_lfsr_en <= 1'b1;
        end
        S_DRAW: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_gap   <= w_gap_sat;
          r_type  <= lfsr_val[1:0];
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tick) begin
            if (r_gap <= CNT_W'(1)) begin
              r_gap <= '0;
              if (w_room) begin
                r_state    <= S_SPAWN;
                r_spawn    <= 1'b1;
                r_obs_type <= r_type;
              end else begin
                r_state   <= S_HOLD;
                r_holding <= 1'b1;
              end
            end else begin
              r_gap <= r_gap - 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_room) begin
            r_state    <= S_SPAWN;
            r_spawn    <= 1'b1;
            r_obs_type <= r_type;
          end else begin
            r_holding <= 1'b1;
          end
        end
        S_SPAWN: begin
          r_state   <= S_DRAW;
          r_lfsr_en <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lfsr_en       = r_lfsr_en;
  assign spawn         = r_spawn;
  assign obstacle_type = r_obs_type;
  assign active_count  = r_active_count;
  assign holding       = r_holding;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Directed bench for obstacle_spawn_scheduler: gap timing, type capture,
// on-screen cap, done bookkeeping, game stop and reset.
module tb_obstacle_spawn_scheduler;

  logic       clk;
  logic       reset;
  logic       game_active;
  logic       tick;
  logic [3:0] lfsr_val;
  logic       obstacle_done;
  logic       lfsr_en;
  logic       spawn;
  logic [1:0] obstacle_type;
  logic [1:0] active_count;
  logic       holding;

  int n_chk;
  int n_pass;
  int sp;

  obstacle_spawn_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .game_active   (game_active),
    .tick          (tick),
    .lfsr_val      (lfsr_val),
    .obstacle_done (obstacle_done),
    .lfsr_en       (lfsr_en),
    .spawn         (spawn),
    .obstacle_type (obstacle_type),
    .active_count  (active_count),
    .holding       (holding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // n tick pulses, each followed by a quiet cycle; counts spawn sightings
  task automatic tick_n(input int n, output int s);
    s = 0;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      s += int'(spawn);
      @(negedge clk);
      s += int'(spawn);
    end
  endtask

  // all but the last tick of a gap, then the expiring tick
  task automatic run_gap(input int n, output int s);
    tick_n(n - 1, s);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    game_active = 1'b1;
    tick = 1'b0;
    lfsr_val = 4'b0011;
    obstacle_done = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outs", {lfsr_en, spawn, obstacle_type, active_count, holding}, 0);
    end
    reset = 1'b0;

    @(negedge clk);
    chk("draw_en", lfsr_en, 1);
    chk("draw_spawn", spawn, 0);
    @(negedge clk);
    chk("en_one_cycle", lfsr_en, 0);
    @(negedge clk);
    sp = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sp += int'(spawn);
    end
    chk("no_tick_no_spawn", sp, 0);

    run_gap(32, sp);
    chk("gap32_early", sp, 0);
    chk("gap32_spawn", spawn, 1);
    chk("gap32_type", obstacle_type, 3);
    @(negedge clk);
    chk("spawn_pulse", spawn, 0);
    chk("type_cleared", obstacle_type, 0);
    chk("cnt_after1", active_count, 1);
    chk("redraw_en", lfsr_en, 1);
    lfsr_val = 4'b0000;
    cyc(2);

    run_gap(20, sp);
    chk("gap20_early", sp, 0);
    chk("gap20_spawn", spawn, 1);
    chk("lockup_type", obstacle_type, 0);
    @(negedge clk);
    chk("cnt_after2", active_count, 2);
    lfsr_val = 4'b0001;
    cyc(2);

    run_gap(24, sp);
    chk("cap_early", sp, 0);
    chk("cap_spawn", spawn, 0);
    chk("cap_holding", holding, 1);
    cyc(2);
    chk("hold_stays", holding, 1);
    chk("hold_nospawn", spawn, 0);
    obstacle_done = 1'b1;
    @(negedge clk);
    obstacle_done = 1'b0;
    chk("done_cnt", active_count, 1);
    chk("done_nospawn", spawn, 0);
    @(negedge clk);
    chk("release_spawn", spawn, 1);
    chk("release_type", obstacle_type, 1);
    chk("release_hold", holding, 0);
    obstacle_done = 1'b1;
    @(negedge clk);
    obstacle_done = 1'b0;
    chk("inc_dec_cnt", active_count, 1);
    chk("inc_dec_en", lfsr_en, 1);
    lfsr_val = 4'b1010;
    cyc(2);

    tick_n(50, sp);
    chk("gap60_part", sp, 0);
    game_active = 1'b0;
    @(negedge clk);
    chk("stop_outs", {lfsr_en, spawn, obstacle_type, holding}, 0);
    chk("stop_cnt", active_count, 0);
    obstacle_done = 1'b1;
    @(negedge clk);
    obstacle_done = 1'b0;
    chk("done_at0", active_count, 0);
    tick_n(15, sp);
    chk("idle_nospawn", sp + int'(lfsr_en), 0);

    lfsr_val = 4'b0000;
    game_active = 1'b1;
    @(negedge clk);
    chk("restart_en", lfsr_en, 1);
    cyc(2);
    run_gap(20, sp);
    chk("restart_spawn", spawn, 1);
    @(negedge clk);
    chk("restart_cnt", active_count, 1);
    lfsr_val = 4'b0010;
    cyc(2);
    tick_n(10, sp);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_outs", {lfsr_en, spawn, obstacle_type, holding}, 0);
    chk("rst_wait_cnt", active_count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_en", lfsr_en, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
